// File: rtl/regfile_bypass.sv
// regfile_bypass: register file with two write ports (B over A), bypassed reads,
// a per-register busy scoreboard, and a self-clearing INIT sequence after reset.
module regfile_bypass #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1_idx,
   input  logic [AW-1:0]   rs2_idx,
   output logic [XLEN-1:0] rs1_val,
   output logic [XLEN-1:0] rs2_val,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wa_en,
   input  logic [AW-1:0]   wa_idx,
   input  logic [XLEN-1:0] wa_data,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_idx,
   input  logic [XLEN-1:0] wb_data,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_rd,
   output logic            init_done
);
   typedef enum logic {INIT, RUN} state_t;
   localparam logic [AW:0] LAST = (AW+1)'(NREG - 1);

   state_t          state, state_nxt;
   logic [AW:0]     cnt, cnt_nxt;
   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy, busy_nxt;
   logic            run, wa_ok, wb_ok, iss_ok;

   // Index 0 is hardwired, so writes and issues to it are filtered here once.
   assign run    = state == RUN;
   assign wa_ok  = run && wa_en && wa_idx != '0;
   assign wb_ok  = run && wb_en && wb_idx != '0;
   assign iss_ok = run && iss_en && iss_rd != '0;
   assign init_done = run;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!run) begin
         cnt_nxt = cnt + 1'b1;
         if (cnt == LAST) state_nxt = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (!run) regs[cnt[AW-1:0]] <= '0;
         if (wa_ok) regs[wa_idx] <= wa_data;
         if (wb_ok) regs[wb_idx] <= wb_data;
      end
   end

   // Issue is applied last so it wins over a same-cycle writeback.
   always_comb begin
      busy_nxt = busy;
      if (wa_ok) busy_nxt[wa_idx] = 1'b0;
      if (wb_ok) busy_nxt[wb_idx] = 1'b0;
      if (iss_ok) busy_nxt[iss_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) busy <= '0;
      else busy <= busy_nxt;
   end

   assign rs1_val = (!run || rs1_idx == '0) ? '0 :
                    (wb_ok && wb_idx == rs1_idx) ? wb_data :
                    (wa_ok && wa_idx == rs1_idx) ? wa_data : regs[rs1_idx];
   assign rs2_val = (!run || rs2_idx == '0) ? '0 :
                    (wb_ok && wb_idx == rs2_idx) ? wb_data :
                    (wa_ok && wa_idx == rs2_idx) ? wa_data : regs[rs2_idx];

   assign rs1_busy = run && busy[rs1_idx] && !(wa_ok && wa_idx == rs1_idx)
                     && !(wb_ok && wb_idx == rs1_idx);
   assign rs2_busy = run && busy[rs2_idx] && !(wa_ok && wa_idx == rs2_idx)
                     && !(wb_ok && wb_idx == rs2_idx);
endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: directed steps; expected read results queued at drive time,
// popped and compared mid-cycle against the DUT.
module tb_regfile_bypass;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs1_idx, rs2_idx, wa_idx, wb_idx, iss_rd;
   logic [31:0] rs1_val, rs2_val, wa_data, wb_data;
   logic        rs1_busy, rs2_busy, wa_en, wb_en, iss_en, init_done;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      string       tag;
      logic        d;
      logic [31:0] v1;
      logic        b1;
      logic [31:0] v2;
      logic        b2;
   } exp_t;
   exp_t sb[$];

   regfile_bypass dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
      .rs1_val(rs1_val), .rs2_val(rs2_val),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wa_en(wa_en), .wa_idx(wa_idx), .wa_data(wa_data),
      .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
      .iss_en(iss_en), .iss_rd(iss_rd),
      .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0;
   endtask

   task automatic step(input string tag, input logic d, input logic [31:0] v1,
                       input logic b1, input logic [31:0] v2, input logic b2);
      exp_t e;
      e.tag = tag; e.d = d; e.v1 = v1; e.b1 = b1; e.v2 = v2; e.b2 = b2;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      cmp({e.tag, ".done"}, {31'b0, init_done}, {31'b0, e.d});
      cmp({e.tag, ".v1"}, rs1_val, e.v1);
      cmp({e.tag, ".b1"}, {31'b0, rs1_busy}, {31'b0, e.b1});
      cmp({e.tag, ".v2"}, rs2_val, e.v2);
      cmp({e.tag, ".b2"}, {31'b0, rs2_busy}, {31'b0, e.b2});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; idle();
      rs1_idx = '0; rs2_idx = '0; wa_idx = '0; wb_idx = '0; iss_rd = '0;
      wa_data = '0; wb_data = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rs1_idx = 5'(i); rs2_idx = 5'(31 - i);
         idle();
         if (i == 3) begin wa_en = 1'b1; wa_idx = 5'd4; wa_data = 32'hCAFE0004; end
         if (i == 5) begin iss_en = 1'b1; iss_rd = 5'd6; end
         step("init", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      end
      idle(); rs1_idx = 5'd4; rs2_idx = 5'd6;
      step("init_end", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

      wa_en = 1'b1; wa_idx = 5'd5; wa_data = 32'hDEADBEEF; rs1_idx = 5'd5; rs2_idx = 5'd4;
      step("wr_byp", 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
      idle();
      step("wr_st1", 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
      step("wr_st2", 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);

      wa_en = 1'b1; wa_idx = 5'd7; wa_data = 32'h1111;
      wb_en = 1'b1; wb_idx = 5'd7; wb_data = 32'h2222; rs2_idx = 5'd7;
      step("coll_byp", 1'b1, 32'hDEADBEEF, 1'b0, 32'h2222, 1'b0);
      idle();
      step("coll_st", 1'b1, 32'hDEADBEEF, 1'b0, 32'h2222, 1'b0);

      wa_en = 1'b1; wa_idx = 5'd8; wa_data = 32'h8888;
      wb_en = 1'b1; wb_idx = 5'd10; wb_data = 32'hAAAA; rs1_idx = 5'd8; rs2_idx = 5'd10;
      step("dual_byp", 1'b1, 32'h8888, 1'b0, 32'hAAAA, 1'b0);
      idle();
      step("dual_st", 1'b1, 32'h8888, 1'b0, 32'hAAAA, 1'b0);

      wa_en = 1'b1; wa_idx = 5'd0; wa_data = 32'h55; iss_en = 1'b1; iss_rd = 5'd0;
      rs1_idx = 5'd0; rs2_idx = 5'd0;
      step("r0_byp", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      idle();
      step("r0_st", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

      iss_en = 1'b1; iss_rd = 5'd3; rs1_idx = 5'd3; rs2_idx = 5'd3;
      step("sb_iss", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      idle();
      step("sb_busy", 1'b1, 32'h0, 1'b1, 32'h0, 1'b1);
      wa_en = 1'b1; wa_idx = 5'd3; wa_data = 32'h33;
      step("sb_wb", 1'b1, 32'h33, 1'b0, 32'h33, 1'b0);
      idle();
      step("sb_free", 1'b1, 32'h33, 1'b0, 32'h33, 1'b0);
      iss_en = 1'b1; iss_rd = 5'd3; wb_en = 1'b1; wb_idx = 5'd3; wb_data = 32'h44;
      step("sb_both", 1'b1, 32'h44, 1'b0, 32'h44, 1'b0);
      idle();
      step("sb_win", 1'b1, 32'h44, 1'b1, 32'h44, 1'b1);

      wa_en = 1'b1; wa_idx = 5'd9; wa_data = 32'hABCD; iss_en = 1'b1; iss_rd = 5'd9;
      rs1_idx = 5'd9; rs2_idx = 5'd11;
      step("r9_set", 1'b1, 32'hABCD, 1'b0, 32'h0, 1'b0);
      idle();
      step("r9_busy", 1'b1, 32'hABCD, 1'b1, 32'h0, 1'b0);
      rst_n = 1'b0; wa_en = 1'b1; wa_data = 32'h1234; iss_en = 1'b1; iss_rd = 5'd11;
      step("rst_cyc", 1'b1, 32'h1234, 1'b0, 32'h0, 1'b0);
      rst_n = 1'b1; idle();
      for (int i = 0; i < 32; i++) step("reinit", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step("reinit_end", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      rs1_idx = 5'd3; rs2_idx = 5'd7;
      step("cleared", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
